// File: rtl/alu_regfile_wb_if.sv
// Decoder-to-stage operation handshake: the decoder offers one decoded op per
// cycle; the stage takes it when valid and ready are both high.
interface alu_regfile_wb_if #(
    parameter int AW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_sel;
    logic [AW-1:0] in_dst;
    logic [AW-1:0] in_srca;
    logic [AW-1:0] in_srcb;
    logic          in_use_imm;
    logic [7:0]    in_imm;

    modport master (
        output in_valid, in_sel, in_dst, in_srca, in_srcb, in_use_imm, in_imm,
        input  in_ready
    );
    modport slave (
        input  in_valid, in_sel, in_dst, in_srca, in_srcb, in_use_imm, in_imm,
        output in_ready
    );
endinterface

// File: rtl/alu_regfile_wb.sv
// Operand fetch, execute latch and writeback around the 8-bit ALU, with a
// single-entry forwarding path so dependent ops issue back to back.
module alu_regfile_wb #(
    parameter int NREGS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_regfile_wb_if.slave      dec,
    input  logic                 hold,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [7:0]           alu_sel,
    input  logic [7:0]           alu_x,
    input  logic [7:0]           alu_flags,
    output logic [7:0]           flags_q,
    output logic                 retire,
    output logic                 illegal_op,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [7:0]           dbg_data
);
    localparam int AW = $clog2(NREGS);

    logic [7:0]    regs [NREGS];
    logic          ex_valid;
    logic [AW-1:0] ex_dst;
    logic          ex_wr;
    logic          ex_fl;

    logic          accept;
    logic          dec_wr, dec_fl, dec_ill;
    logic [7:0]    fwd_a, fwd_b;

    assign dec.in_ready = ~hold;
    assign accept       = dec.in_valid & ~hold;
    assign retire       = ex_valid & ~hold;
    assign dbg_data     = regs[dbg_addr];

    // The op in the latch commits on the same edge the new op is captured,
    // so its result must bypass the register file.
    always_comb begin
        fwd_a = regs[dec.in_srca];
        fwd_b = regs[dec.in_srcb];
        if (ex_valid && ex_wr && ex_dst == dec.in_srca) fwd_a = alu_x;
        if (ex_valid && ex_wr && ex_dst == dec.in_srcb) fwd_b = alu_x;
        if (dec.in_use_imm) fwd_b = dec.in_imm;
    end

    always_comb begin
        dec_wr  = 1'b0;
        dec_fl  = 1'b0;
        dec_ill = 1'b0;
        if (dec.in_sel >= 8'h01 && dec.in_sel <= 8'h0E) begin
            dec_wr = 1'b1;
            dec_fl = 1'b1;
        end else if (dec.in_sel == 8'h0F) begin
            dec_fl = 1'b1;
        end else if (dec.in_sel == 8'h80) begin
            dec_wr = 1'b1;
        end else begin
            dec_ill = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
            flags_q    <= 8'h00;
            ex_valid   <= 1'b0;
            ex_dst     <= '0;
            ex_wr      <= 1'b0;
            ex_fl      <= 1'b0;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_sel    <= 8'h00;
            illegal_op <= 1'b0;
        end else if (!hold) begin
            if (ex_valid && ex_wr) regs[ex_dst] <= alu_x;
            if (ex_valid && ex_fl) flags_q <= alu_flags;
            if (accept) begin
                ex_valid <= 1'b1;
                ex_dst   <= dec.in_dst;
                ex_wr    <= dec_wr;
                ex_fl    <= dec_fl;
                alu_sel  <= dec.in_sel;
                alu_a    <= fwd_a;
                alu_b    <= fwd_b;
                if (dec_ill) illegal_op <= 1'b1;
            end else begin
                // Idle code to the ALU; operands are left as they were.
                ex_valid <= 1'b0;
                alu_sel  <= 8'h00;
            end
        end
    end
endmodule

// File: doc/alu_regfile_wb.md
# alu_regfile_wb

Operand-fetch and writeback stage wrapped around the 8-bit ALU. It accepts decoded operations from the decoder and holds eight 8-bit general registers plus the architectural flags register. It registers operands and selector into an execute latch that drives the ALU, then writes the ALU result and flags back on the following edge. A result-forwarding path allows back-to-back dependent operations at one operation per cycle.

## Interface
Parameters:
- NREGS, 8, number of general registers (address width 3)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decoder presents an operation
- in_ready  out  1  stage accepts the operation; equals ~hold
- in_sel  in  8  ALU selector code
- in_dst  in  3  destination register
- in_srca  in  3  source register for ALU A
- in_srcb  in  3  source register for ALU B
- in_use_imm  in  1  1: ALU B comes from in_imm instead of in_srcb
- in_imm  in  8  immediate operand
- hold  in  1  pipeline freeze (memory/bus stall)
- alu_a, alu_b, alu_sel  out  8 each  registered operands and selector driving the ALU
- alu_x  in  8  ALU result
- alu_flags  in  8  ALU flags
- flags_q  out  8  architectural flags register
- retire  out  1  combinational; high in the cycle the execute latch commits
- illegal_op  out  1  sticky; set by an unknown selector
- dbg_addr  in  3  debug read address
- dbg_data  out  8  combinational register-file read, not forwarded

## Operation
- **Execute latch:** ex_valid, alu_sel, alu_a, alu_b, ex_dst, ex_wr (writes reg), ex_fl (writes flags).
- **Accept:** an operation is accepted when in_valid & in_ready. On accept, the latch loads:
  - alu_sel = in_sel
  - alu_a = fwd(in_srca)
  - alu_b = in_use_imm ? in_imm : fwd(in_srcb)
- **Forwarding:** fwd(r) = (ex_valid & ex_wr & ex_dst==r) ? alu_x : regs[r].
- **Empty latch:** if no operation is accepted and hold=0, ex_valid←0 and alu_sel←0x00 (ALU idle code). alu_a and alu_b keep their values.
- **Commit:** retire = ex_valid & ~hold. On the retire edge:
  - if ex_wr, regs[ex_dst]←alu_x
  - if ex_fl, flags_q←alu_flags
- **Selector decode** (done at accept):
  - 0x01–0x0E (arith, logic, shifts): ex_wr=1, ex_fl=1
  - 0x0F (compare): ex_wr=0, ex_fl=1
  - 0x80 (MOV, result = A): ex_wr=1, ex_fl=0; flags are preserved
  - any other code: ex_wr=0, ex_fl=0, and illegal_op←1 on accept. The operation still occupies the latch and retires as a no-op.
- Register 0 is an ordinary register, not hardwired to zero.
- Loading a constant: OR rd, r0, imm with r0 known to be zero.

## Timing
- **Reset (async, immediate):** regs all 0x00, flags_q=0x00, ex_valid=0, alu_a/alu_b/alu_sel=0x00, illegal_op=0, retire=0.
- **Reset mid-operation:** the in-flight operation is discarded with no write.
- **Latency:** accept at edge N → ALU inputs valid after N → commit at edge N+1 → visible on dbg_data after N+1.
- **Throughput:** one operation per cycle while hold=0. A dependent operation issued on the very next cycle gets alu_x through forwarding, with no bubble.
- **hold=1:**
  - in_ready=0, retire=0
  - the latch is frozen, so ALU inputs are stable
  - no register or flags write
  - commit happens on the first edge with hold=0
- **Simultaneous commit and accept of the same register:** the new operation uses the forwarded alu_x, never the stale regs value.
- **Self-dependence:** when srca==srcb==ex_dst, both operands are forwarded.
- **No structural hazard:** the single write port is used only by commit.
- **Operand widths:** all 8-bit. ALU overflow and carry are reported only through flags; no width extension occurs here.

## Test plan
- **Forwarding chain:** after reset, issue on consecutive cycles: OR r1=r0|imm 0x05; OR r2=r0|imm 0x03; ADD (0x01) r3=r1+r2. Required: r3=0x08, flags_q=0x00, one retire per cycle, no bubble.
- **Zero/parity flags and no-write:**
  - AND (0x06) r4=r1&imm 0x02 → r4=0x00, flags_q=0x09.
  - Then CMP (0x0F) r1 vs r2, dst=r3 → flags_q=0x02 and r3 stays 0x08.
- **MOV preserves flags:** MOV (0x80) r5=r3 → r5=0x08; flags_q stays 0x02.
- **Illegal selector:** issue in_sel=0x20 with dst=r1 → illegal_op=1 and stays 1, r1 stays 0x05, flags_q unchanged, retire pulses once.
- **Hold:** hold=1 for 3 cycles while ADD r6=r1+r1 sits in the latch. Required: in_ready=0, retire=0, r6 unchanged, alu_a/alu_b stable at 0x05. After hold drops: r6=0x0A on the next edge.
- **Reset mid-operation:** assert rst while an ADD to r7 is in the latch. Required: immediately all outputs at reset values, r7=0x00, illegal_op=0, flags_q=0x00.
